// File: rtl/fc_sequencer.sv
// Sequences one sample at a time through the fc network: forward pass, then an optional backward pass. Results are held under m_ready backpressure.
// All outputs are registered. Defining FC_SEQ_WATCHDOG_EN adds a timeout that aborts a FWD or BWD wait that stalls.
module fc_sequencer #(
  parameter int N       = 27,
  parameter int OSC_DIV = 4,
  parameter int TIMEOUT = 256
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_data,
  input  logic [N-1:0] s_target,
  input  logic         s_train,
  output logic [N-1:0] fc_fin,
  output logic [N-1:0] fc_bin,
  output logic         fc_fd_prop,
  output logic         fc_bk_prop,
  input  logic         fc_fd_done,
  input  logic         fc_bk_done,
  input  logic [N-1:0] fc_fout,
  output logic         oscillator,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_data,
  output logic [N-1:0] m_err,
  output logic         m_timeout,
  output logic [15:0]  pass_count
);
  localparam int OW = (OSC_DIV > 1) ? $clog2(OSC_DIV) : 1;

  typedef enum logic [1:0] {IDLE, FWD, BWD, OUT} state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_target;
  logic          r_train;
  logic [OW-1:0] r_osc_cnt;
  logic [N-1:0]  w_err;
  logic          w_accept, w_fd_hit, w_wd_hit, w_out_hs, w_wd_expired;

  assign w_err = fc_fout ^ r_target;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A done pulse coincident with its own start pulse belongs to the previous pass and is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fd_hit    = 1'b0;
    w_wd_hit    = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_valid && s_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = FWD;
        end
      end
      FWD: begin
        if (fc_fd_done && !fc_fd_prop) begin
          w_fd_hit    = 1'b1;
          w_state_nxt = r_train ? BWD : OUT;
        end else if (w_wd_expired) begin
          w_wd_hit    = 1'b1;
          w_state_nxt = OUT;
        end
      end
      BWD: begin
        if (fc_bk_done && !fc_bk_prop) begin
          w_state_nxt = OUT;
        end else if (w_wd_expired) begin
          w_wd_hit    = 1'b1;
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (m_valid && m_ready) begin
          w_out_hs    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_ready    <= 1'b1;
      m_valid    <= 1'b0;
      fc_fd_prop <= 1'b0;
      fc_bk_prop <= 1'b0;
      fc_fin     <= '0;
      fc_bin     <= '0;
      r_target   <= '0;
      r_train    <= 1'b0;
      m_data     <= '0;
      m_err      <= '0;
      pass_count <= '0;
    end else begin
      s_ready    <= (w_state_nxt == IDLE);
      m_valid    <= (w_state_nxt == OUT);
      fc_fd_prop <= w_accept;
      fc_bk_prop <= w_fd_hit && r_train;
      if (w_accept) begin
        fc_fin   <= s_data;
        r_target <= s_target;
        r_train  <= s_train;
      end
      if (w_fd_hit) begin
        m_data <= fc_fout;
        m_err  <= w_err;
        if (r_train) fc_bin <= w_err;
      end
      if (w_wd_hit) begin
        m_data <= '0;
        m_err  <= '0;
      end
      if (w_out_hs) pass_count <= pass_count + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_osc_cnt  <= '0;
      oscillator <= 1'b0;
    end else if (r_osc_cnt == OW'(OSC_DIV - 1)) begin
      r_osc_cnt  <= '0;
      oscillator <= ~oscillator;
    end else begin
      r_osc_cnt  <= r_osc_cnt + 1'b1;
    end
  end

`ifdef FC_SEQ_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wd_cnt;

  // Counter is zero in the first cycle of FWD/BWD, so expiry lands after TIMEOUT waiting cycles.
  assign w_wd_expired = (r_wd_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wd_cnt  <= '0;
      m_timeout <= 1'b0;
    end else begin
      if (w_accept || w_fd_hit)                r_wd_cnt <= '0;
      else if (r_state == FWD || r_state == BWD) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_wd_hit)      m_timeout <= 1'b1;
      else if (w_out_hs) m_timeout <= 1'b0;
    end
  end
`else
  assign w_wd_expired = (TIMEOUT < 0);
  assign m_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed test-plan cases followed by randomized transactions, checked against a cycle-level transaction model.
module tb_fc_sequencer;
  localparam int N       = 27;
  localparam int OSC_DIV = 4;
  localparam int TIMEOUT = 16;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         s_valid, s_ready, s_train;
  logic [N-1:0] s_data, s_target;
  logic [N-1:0] fc_fin, fc_bin, fc_fout;
  logic         fc_fd_prop, fc_bk_prop, fc_fd_done, fc_bk_done;
  logic         oscillator, m_valid, m_ready, m_timeout;
  logic [N-1:0] m_data, m_err;
  logic [15:0]  pass_count;

  fc_sequencer #(.N(N), .OSC_DIV(OSC_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_target(s_target), .s_train(s_train),
    .fc_fin(fc_fin), .fc_bin(fc_bin), .fc_fd_prop(fc_fd_prop), .fc_bk_prop(fc_bk_prop),
    .fc_fd_done(fc_fd_done), .fc_bk_done(fc_bk_done), .fc_fout(fc_fout),
    .oscillator(oscillator), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_err(m_err), .m_timeout(m_timeout), .pass_count(pass_count)
  );

  always #5 clk_in = ~clk_in;

  int           n_assert = 0;
  int           n_fail   = 0;
  int           edges    = 0;
  int           exp_pass = 0;
  logic [N-1:0] exp_bin  = '0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the oscillator is expected to flip once every OSC_DIV edges out of reset.
  task automatic step();
    @(posedge clk_in);
    if (!rst_in) edges++;
    #1;
    check1("oscillator", oscillator, 1'((edges / OSC_DIV) % 2));
  endtask

  task automatic check_reset_outputs();
    check1("rst_s_ready", s_ready, 1'b1);
    checkv("rst_fc_fin", fc_fin, '0);
    checkv("rst_fc_bin", fc_bin, '0);
    check1("rst_fd_prop", fc_fd_prop, 1'b0);
    check1("rst_bk_prop", fc_bk_prop, 1'b0);
    check1("rst_oscillator", oscillator, 1'b0);
    check1("rst_m_valid", m_valid, 1'b0);
    checkv("rst_m_data", m_data, '0);
    checkv("rst_m_err", m_err, '0);
    check1("rst_m_timeout", m_timeout, 1'b0);
    checkp("rst_pass_count", pass_count, '0);
  endtask

  // One complete transaction: done arrives fd_lat (bk_lat) cycles after its start pulse, m_ready held low for stall cycles.
  task automatic run_txn(input logic [N-1:0] data, input logic [N-1:0] target, input logic [N-1:0] fout,
                         input logic train, input int fd_lat, input int bk_lat, input int stall);
    logic [N-1:0] err;
    err = fout ^ target;
    check1("idle_s_ready", s_ready, 1'b1);
    s_valid = 1'b1; s_data = data; s_target = target; s_train = train;
    fc_fd_done = 1'($urandom); fc_bk_done = 1'($urandom);
    step();
    s_valid = 1'($urandom); s_data = N'($urandom); s_target = N'($urandom); s_train = 1'($urandom);
    check1("fd_prop_first", fc_fd_prop, 1'b1);
    checkv("fc_fin", fc_fin, data);
    check1("busy_s_ready", s_ready, 1'b0);
    fc_fd_done = 1'($urandom); fc_fout = N'($urandom);
    for (int c = 2; c <= fd_lat + 1; c++) begin
      step();
      check1("fd_prop_once", fc_fd_prop, 1'b0);
      check1("fwd_no_bk_prop", fc_bk_prop, 1'b0);
      check1("fwd_m_valid", m_valid, 1'b0);
      fc_fd_done = (c == fd_lat + 1);
      fc_fout    = (c == fd_lat + 1) ? fout : N'($urandom);
      fc_bk_done = 1'($urandom);
    end
    step();
    fc_fd_done = 1'($urandom); fc_fout = N'($urandom);
    if (train) begin
      exp_bin = err;
      check1("bk_prop_first", fc_bk_prop, 1'b1);
      checkv("fc_bin", fc_bin, err);
      check1("bwd_m_valid", m_valid, 1'b0);
      fc_bk_done = 1'($urandom);
      for (int c = 2; c <= bk_lat + 1; c++) begin
        step();
        check1("bk_prop_once", fc_bk_prop, 1'b0);
        check1("bwd_wait_m_valid", m_valid, 1'b0);
        fc_bk_done = (c == bk_lat + 1);
      end
      step();
    end
    check1("out_m_valid", m_valid, 1'b1);
    check1("out_bk_prop", fc_bk_prop, 1'b0);
    check1("out_m_timeout", m_timeout, 1'b0);
    checkv("fc_bin_hold", fc_bin, exp_bin);
    m_ready = 1'b0;
    for (int c = 0; c <= stall; c++) begin
      if (c > 0) begin
        fc_fd_done = 1'($urandom); fc_bk_done = 1'($urandom); fc_fout = N'($urandom);
        step();
      end
      check1("hold_m_valid", m_valid, 1'b1);
      check1("hold_s_ready", s_ready, 1'b0);
      checkv("m_data", m_data, fout);
      checkv("m_err", m_err, err);
      checkv("hold_fc_fin", fc_fin, data);
      checkp("hold_pass_count", pass_count, 16'(exp_pass));
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0; s_valid = 1'b0; fc_fd_done = 1'b0; fc_bk_done = 1'b0;
    exp_pass = (exp_pass + 1) % 65536;
    check1("bubble_m_valid", m_valid, 1'b0);
    check1("bubble_s_ready", s_ready, 1'b1);
    checkp("pass_count_inc", pass_count, 16'(exp_pass));
  endtask

  initial begin
    rst_in = 1'b1; s_valid = 1'b0; s_data = '0; s_target = '0; s_train = 1'b0;
    fc_fd_done = 1'b0; fc_bk_done = 1'b0; fc_fout = '0; m_ready = 1'b0;
    step();
    step();
    check_reset_outputs();
    rst_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check1("idle_s_ready_stays", s_ready, 1'b1);
      check1("idle_m_valid", m_valid, 1'b0);
    end

    run_txn(27'h1, 27'h3, 27'h2, 1'b0, 3, 1, 0);
    run_txn(27'h1, 27'h3, 27'h2, 1'b1, 3, 2, 0);
    run_txn(27'h5A5A5A5, 27'h0F0F0F0, 27'h7FFFFFF, 1'b1, 1, 1, 10);
    run_txn(27'h0, 27'h7FFFFFF, 27'h0, 1'b0, 1, 1, 10);

    for (int t = 0; t < 25; t++) begin
      run_txn(N'($urandom), N'($urandom), N'($urandom), 1'($urandom),
              int'($urandom_range(8, 1)), int'($urandom_range(8, 1)), int'($urandom_range(3, 0)));
    end

    // Reset while the backward pass is in flight.
    s_valid = 1'b1; s_data = 27'h123; s_target = 27'h456; s_train = 1'b1; fc_fd_done = 1'b0;
    step();
    s_valid = 1'b0;
    step();
    fc_fd_done = 1'b1; fc_fout = 27'h789;
    step();
    fc_fd_done = 1'b0;
    check1("pre_rst_bk_prop", fc_bk_prop, 1'b1);
    step();
    #2;
    rst_in = 1'b1;
    #1;
    edges = 0; exp_pass = 0; exp_bin = '0;
    check_reset_outputs();
    step();
    check1("rst_hold_fd_prop", fc_fd_prop, 1'b0);
    check1("rst_hold_bk_prop", fc_bk_prop, 1'b0);
    step();
    rst_in = 1'b0;
    run_txn(27'h2AA, 27'h155, 27'h3FF, 1'b1, 2, 3, 1);

`ifdef FC_SEQ_WATCHDOG_EN
    s_valid = 1'b1; s_data = 27'h42; s_target = 27'h24; s_train = 1'b0; fc_fd_done = 1'b0; fc_fout = 27'h1;
    step();
    s_valid = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      check1("wd_wait_m_valid", m_valid, 1'b0);
      step();
    end
    check1("wd_m_valid", m_valid, 1'b1);
    check1("wd_m_timeout", m_timeout, 1'b1);
    checkv("wd_m_data", m_data, '0);
    checkv("wd_m_err", m_err, '0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    exp_pass = (exp_pass + 1) % 65536;
    check1("wd_timeout_clear", m_timeout, 1'b0);
    check1("wd_s_ready", s_ready, 1'b1);
    checkp("wd_pass_count", pass_count, 16'(exp_pass));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_sequencer.md
# fc_sequencer

Transaction-level controller for the `fc` ternary fully-connected network. It accepts one sample at a time through a valid/ready port and drives the `fc` input bus. It issues the one-cycle `fd_prop` pulse, waits for `fd_prop_done`, and captures the output. For training samples it also computes the error vector, drives it onto `bin`, pulses `bk_prop` and waits for `bk_prop_done`. It also generates the free-running `oscillator` the `fc` units consume, and returns results on a valid/ready output port.

## Interface
Parameters:
- `N`, 27, network width; must match the connected `fc`.
- `OSC_DIV`, 4, `oscillator` half-period in clock cycles (≥1).
- `TIMEOUT`, 256, watchdog limit in cycles (used only with `FC_SEQ_WATCHDOG_EN`).

Ports:
- `clk_in` in 1: the block's only clock.
- `rst_in` in 1: reset; asynchronous, active-high.
- `s_valid` in 1: sample request.
- `s_ready` out 1: sequencer can accept a sample.
- `s_data` in N: network input vector.
- `s_target` in N: expected output.
- `s_train` in 1: 1 means run the backward pass after the forward pass.
- `fc_fin` out N: to `fc.fin`.
- `fc_bin` out N: to `fc.bin`.
- `fc_fd_prop` out 1: forward start pulse.
- `fc_bk_prop` out 1: backward start pulse.
- `fc_fd_done` in 1: from `fc.fd_prop_done`.
- `fc_bk_done` in 1: from `fc.bk_prop_done`.
- `fc_fout` in N: from `fc.fout`.
- `oscillator` out 1: to `fc.oscillator`.
- `m_valid` out 1: result available.
- `m_ready` in 1: consumer accepts the result.
- `m_data` out N: captured `fc_fout`.
- `m_err` out N: `fc_fout ^ s_target`, as captured.
- `m_timeout` out 1: watchdog abort flag for this result.
- `pass_count` out 16: completed transactions, wraps at 2^16.

## Operation
- States: IDLE, FWD, BWD, OUT.
- IDLE:
  - `s_ready`=1.
  - On `s_valid&&s_ready`: latch `s_target` and `s_train`, load `fc_fin<=s_data`, go to FWD.
  - `fc_fd_prop` is registered, so it is high for exactly the first FWD cycle.
- FWD:
  - `fc_fd_done` is ignored in the cycle `fc_fd_prop` is high.
  - On a later `fc_fd_done`: `m_data<=fc_fout` and `m_err<=fc_fout^target`.
  - If train=1: `fc_bin<=fc_fout^target`, then go to BWD with `fc_bk_prop` high for exactly its first cycle. If train=0: go to OUT.
- BWD:
  - `fc_bk_done` is ignored in the `fc_bk_prop` cycle.
  - On a later `fc_bk_done`: go to OUT.
- OUT:
  - `m_valid`=1. `m_data`, `m_err` and `m_timeout` are held stable.
  - On `m_valid&&m_ready`: `pass_count++`, go to IDLE.
- `s_ready` is 0 in every state except IDLE. Inputs are not sampled outside IDLE.
- `fc_fin` and `fc_bin` hold their last value until next loaded; the `fc` may sample them at any time during a pass.
- Oscillator:
  - A counter from 0 to OSC_DIV-1 runs in all states.
  - `oscillator` toggles each time the counter wraps.
- Done pulses arriving in IDLE or OUT are ignored.
- Reset mid-operation: all state is discarded immediately and no further start pulse is issued. The `fc` itself is reset by the same `rst_in`.
- Reset values:
  - state=IDLE, `s_ready`=1.
  - `fc_fin`=`fc_bin`=0, `fc_fd_prop`=`fc_bk_prop`=0.
  - `oscillator`=0, `m_valid`=0, `m_data`=`m_err`=0, `m_timeout`=0, `pass_count`=0.

## Timing
- Acceptance at edge 0:
  - `fc_fd_prop` and `fc_fin` are valid in cycle 1.
  - `fc_fd_done` first seen in cycle k (k≥2) gives OUT with `m_valid`=1 in cycle k+1 for inference.
- Training:
  - `fc_bk_prop` is high in cycle k+1.
  - `fc_bk_done` in cycle j gives `m_valid` in cycle j+1.
- After the output handshake at edge t, `s_ready`=1 in cycle t+1, giving one bubble cycle per transaction.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `FC_SEQ_WATCHDOG_EN` defined:
  - A cycle counter restarts on entering FWD or BWD.
  - If it reaches TIMEOUT with no done, go to OUT with `m_timeout`=1 and `m_data`=`m_err`=0.
  - `m_timeout` clears on the output handshake.
- Not defined:
  - FWD and BWD wait indefinitely.
  - `m_timeout` is tied to 0.
  - No counter logic is synthesized.

## Test plan
- Reset, then idle: all outputs at reset values; `oscillator` toggles every 4 cycles (OSC_DIV=4).
- Inference: accept `s_data`=27'h1, `s_target`=27'h3, train=0; the model returns done 3 cycles after `fd_prop` with fout=27'h2. Required: `fd_prop` exactly 1 cycle, no `bk_prop`, `m_data`=27'h2, `m_err`=27'h1, `m_valid` 4 cycles after the `fd_prop` cycle.
- Training: same sample with train=1. Required: `fc_bin`=27'h1 and a single `bk_prop` 1 cycle after `fd_done`; `m_valid` 1 cycle after `bk_done`.
- Backpressure: hold `m_ready`=0 for 10 cycles. Required: outputs stable, `s_ready`=0, `s_valid` ignored, `pass_count` unchanged until the handshake, then +1.
- Reset asserted in BWD: all outputs return to reset values asynchronously; after release, a new sample proceeds normally.
- With `FC_SEQ_WATCHDOG_EN` and TIMEOUT=16, never assert `fd_done`: OUT after 16 cycles with `m_timeout`=1 and `m_data`=0.
